sync_fifo: RTL and testbench

SYNC_FIFO -- requirements
Module: sync_fifo

---
 rtl/shared_pkg.sv | 10 +
 rtl/fifo_mem.sv | 52 +++++
 rtl/sync_fifo.sv | 121 ++++++++++++
 tb/tb_sync_fifo.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/shared_pkg.sv
// Shared constants for the synchronous FIFO slice.
//
// FIFO_WIDTH_DEF : default data word width in bits
// FIFO_DEPTH_DEF : default number of storage entries (power of two, >= 4)
package shared_pkg;

    localparam int FIFO_WIDTH_DEF = 16;
    localparam int FIFO_DEPTH_DEF = 8;

endpackage : shared_pkg

// File: rtl/fifo_mem.sv
// Register-array storage for sync_fifo: one write port, one registered read port.
//
// Ports:
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset, clears only the read data register
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   re_i     : read enable, loads rdata_o from raddr_i
//   raddr_i  : read address
//   rdata_o  : registered read data
module fifo_mem
    import shared_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH_DEF,
    parameter int DEPTH = FIFO_DEPTH_DEF,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // The array itself is never reset; stale entries are unreachable
    // because the read pointer only visits addresses written since reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Same-address read/write on one edge cannot occur with an accepted read:
    // the pointers only coincide when empty (no read) or full (no write).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : fifo_mem

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, status pulses and occupancy flags.
//
// Ports:
//   clk         : clock, rising edge
//   rst_n       : asynchronous active-low reset
//   data_in     : write data, captured on an accepted write
//   wr_en       : write request
//   rd_en       : read request
//   data_out    : registered read data (1-cycle latency), holds when no read
//   wr_ack      : pulse, previous-cycle write accepted
//   overflow    : pulse, previous-cycle write rejected because full
//   underflow   : pulse, previous-cycle read rejected because empty
//   full        : count == FIFO_DEPTH
//   empty       : count == 0
//   almostfull  : count == FIFO_DEPTH-1
//   almostempty : count == 1
//   count       : current occupancy
module sync_fifo
    import shared_pkg::*;
#(
    parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    localparam int AW        = $clog2(FIFO_DEPTH),
    localparam int CW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty,
    output logic [CW-1:0]         count
);

    if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo: FIFO_DEPTH must be a power of two and at least 4");
    end

    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          wr_ack_q, overflow_q, underflow_q;
    logic          wr_accept, rd_accept;

    // Flags are purely combinational from the occupancy register.
    assign full        = (count_q == DEPTH_C);
    assign empty       = (count_q == '0);
    assign almostfull  = (count_q == DEPTH_C - CW'(1));
    assign almostempty = (count_q == CW'(1));

    // Acceptance is judged on the current occupancy, so a full FIFO refuses
    // a write even when a read frees a slot on the same edge, and an empty
    // FIFO refuses a read even when a write lands on the same edge.
    assign wr_accept = wr_en && !full;
    assign rd_accept = rd_en && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Power-of-two depth: pointers wrap by natural overflow.
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            wr_ack_q    <= wr_accept;
            overflow_q  <= wr_en && full;
            underflow_q <= rd_en && empty;
        end
    end

    fifo_mem #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (wr_accept),
        .waddr_i (wr_ptr_q),
        .wdata_i (data_in),
        .re_i    (rd_accept),
        .raddr_i (rd_ptr_q),
        .rdata_o (data_out)
    );

    assign wr_ack    = wr_ack_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign count     = count_q;

endmodule : sync_fifo

// File: tb/tb_sync_fifo.sv
module tb_sync_fifo;

    logic        clk;
    logic        rst_n;
    logic [15:0] data_in;
    logic        wr_en;
    logic        rd_en;
    logic [15:0] data_out;
    logic        wr_ack;
    logic        overflow;
    logic        underflow;
    logic        full;
    logic        empty;
    logic        almostfull;
    logic        almostempty;
    logic [3:0]  count;

    int total = 0;
    int bad   = 0;

    logic [15:0] model_q[$];
    logic [15:0] exp_word;

    sync_fifo #(
        .FIFO_WIDTH (16),
        .FIFO_DEPTH (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_in     (data_in),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .data_out    (data_out),
        .wr_ack      (wr_ack),
        .overflow    (overflow),
        .underflow   (underflow),
        .full        (full),
        .empty       (empty),
        .almostfull  (almostfull),
        .almostempty (almostempty),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of requests, then sample 1 time unit after the edge.
    task automatic step(input logic w, input logic r, input logic [15:0] d);
        wr_en   = w;
        rd_en   = r;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_count"},  32'(count),       32'd0);
        chk({tag, "_empty"},  32'(empty),       32'd1);
        chk({tag, "_full"},   32'(full),        32'd0);
        chk({tag, "_afull"},  32'(almostfull),  32'd0);
        chk({tag, "_aempty"}, 32'(almostempty), 32'd0);
        chk({tag, "_dout"},   32'(data_out),    32'd0);
        chk({tag, "_wrack"},  32'(wr_ack),      32'd0);
        chk({tag, "_ovf"},    32'(overflow),    32'd0);
        chk({tag, "_udf"},    32'(underflow),   32'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        data_in = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_reset_state("rst");
        rst_n = 1'b1;

        // Read from empty right after reset.
        step(1'b0, 1'b1, 16'h0000);
        chk("udf_pulse", 32'(underflow), 32'd1);
        chk("udf_dout",  32'(data_out),  32'h0000);
        chk("udf_count", 32'(count),     32'd0);
        chk("udf_empty", 32'(empty),     32'd1);
        step(1'b0, 1'b0, 16'h0000);
        chk("udf_clear", 32'(underflow), 32'd0);

        // Fill with one-hot words.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 16'(1 << i));
            chk($sformatf("fill%0d_ack", i),   32'(wr_ack),     32'd1);
            chk($sformatf("fill%0d_count", i), 32'(count),      32'(i + 1));
            chk($sformatf("fill%0d_afull", i), 32'(almostfull), 32'(i == 6));
            chk($sformatf("fill%0d_full", i),  32'(full),       32'(i == 7));
            chk($sformatf("fill%0d_aempty", i), 32'(almostempty), 32'(i == 0));
        end

        // Write when full is rejected.
        step(1'b1, 1'b0, 16'hFFFF);
        chk("ovf_pulse", 32'(overflow), 32'd1);
        chk("ovf_ack",   32'(wr_ack),   32'd0);
        chk("ovf_count", 32'(count),    32'd8);
        chk("ovf_full",  32'(full),     32'd1);
        step(1'b0, 1'b0, 16'hFFFF);
        chk("ovf_clear", 32'(overflow), 32'd0);

        // Write+read when full: only the read is taken.
        step(1'b1, 1'b1, 16'h1234);
        chk("fullrw_ovf",   32'(overflow), 32'd1);
        chk("fullrw_ack",   32'(wr_ack),   32'd0);
        chk("fullrw_count", 32'(count),    32'd7);
        chk("fullrw_dout",  32'(data_out), 32'h0001);
        chk("fullrw_afull", 32'(almostfull), 32'd1);

        // Drain the rest; neither 0xFFFF nor 0x1234 may appear.
        for (int i = 1; i < 8; i++) begin
            step(1'b0, 1'b1, 16'hFFFF);
            chk($sformatf("drain%0d_dout", i),  32'(data_out), 32'(1 << i));
            chk($sformatf("drain%0d_count", i), 32'(count),    32'(7 - i));
        end
        chk("drain_empty", 32'(empty), 32'd1);

        // Read when empty: data_out holds the last word.
        step(1'b0, 1'b1, 16'h0000);
        chk("udf2_pulse", 32'(underflow), 32'd1);
        chk("udf2_hold",  32'(data_out),  32'h0080);

        // Write+read when empty: only the write is taken.
        step(1'b1, 1'b1, 16'hA5A5);
        chk("emptyrw_count",  32'(count),       32'd1);
        chk("emptyrw_ack",    32'(wr_ack),      32'd1);
        chk("emptyrw_udf",    32'(underflow),   32'd1);
        chk("emptyrw_aempty", 32'(almostempty), 32'd1);
        chk("emptyrw_hold",   32'(data_out),    32'h0080);
        step(1'b0, 1'b1, 16'h0000);
        chk("emptyrw_rd",     32'(data_out),    32'hA5A5);
        chk("emptyrw_count0", 32'(count),       32'd0);
        chk("emptyrw_udf0",   32'(underflow),   32'd0);

        // Preload four words, then steady-state write+read across the wrap.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 16'(16'h0100 + i));
            model_q.push_back(16'(16'h0100 + i));
        end
        chk("pre_count", 32'(count), 32'd4);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 16'(16'h0200 + i));
            exp_word = model_q.pop_front();
            model_q.push_back(16'(16'h0200 + i));
            chk($sformatf("rw%0d_dout", i),  32'(data_out), 32'(exp_word));
            chk($sformatf("rw%0d_count", i), 32'(count),    32'd4);
            chk($sformatf("rw%0d_ack", i),   32'(wr_ack),   32'd1);
        end

        // Bring to five entries, then assert reset in the middle of a write cycle.
        step(1'b1, 1'b0, 16'h0300);
        chk("pre_rst_count", 32'(count), 32'd5);
        wr_en   = 1'b1;
        data_in = 16'h0301;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_state("async_rst");
        repeat (3) step(1'b1, 1'b1, 16'hDEAD);
        chk_reset_state("hold_rst");
        rst_n = 1'b1;

        // Nothing survives reset: the first read underflows.
        step(1'b0, 1'b1, 16'h0000);
        chk("post_rst_udf",   32'(underflow), 32'd1);
        chk("post_rst_dout",  32'(data_out),  32'h0000);
        chk("post_rst_count", 32'(count),     32'd0);

        // First edge after release accepts a write; it reads back correctly.
        step(1'b1, 1'b0, 16'h4242);
        chk("post_rst_ack", 32'(wr_ack), 32'd1);
        step(1'b0, 1'b1, 16'h0000);
        chk("post_rst_rd",  32'(data_out), 32'h4242);
        step(1'b0, 1'b0, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sync_fifo
